ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter: it sends command bytes from the FPGA to the mouse, such as reset (0xFF) and enable data reporting (0xF4). It sits beside `MouseCtl` on the 94.5 MHz clock and shares the `PS2Clk`/`PS2Data` open-drain lines with it; the top level turns its pull-low enables into tristate drivers. It handles the whole transaction: clock inhibit, request-to-send, serialising on the device clock, odd parity, stop bit, and ACK check with timeouts.

---
 rtl/ps2_pkg.sv | 39 +++
 rtl/ps2_host_tx_if.sv | 22 ++
 rtl/ps2_line_sync.sv | 38 +++
 rtl/ps2_host_tx.sv | 154 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-side blocks (transmitter and
// receiver). Cycle counts assume the 94.5 MHz system clock.
package ps2_pkg;

  // Transmitter FSM states.
  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RTS,
    S_WAIT_START,
    S_SHIFT,
    S_DONE_OK,
    S_ERR
  } ps2_tx_state_e;

  // Mouse command / response bytes.
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // Default cycle counts at 94.5 MHz.
  localparam int unsigned INHIBIT_CYC_DEF  = 9450;     // 100 us clock inhibit
  localparam int unsigned RTS_CYC_DEF      = 95;       // data low before clock release
  localparam int unsigned START_TO_CYC_DEF = 1417500;  // 15 ms for the first device clock
  localparam int unsigned PKT_TO_CYC_DEF   = 189000;   // 2 ms first fall to ACK

  // Width of the shared timeout counter; large enough for START_TO_CYC_DEF.
  localparam int unsigned TO_W = 21;

  // Falls on the device clock in one host-to-device frame.
  localparam int unsigned FRAME_FALLS = 11;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Host-side command handshake of the PS/2 transmitter. The master issues
// command bytes; the slave (the transmitter) reports completion status.
interface ps2_host_tx_if;

  logic [7:0] tx_data;   // command byte
  logic       tx_valid;  // request, taken when tx_valid && tx_ready
  logic       tx_ready;  // transmitter idle and able to take a byte
  logic       done;      // one-cycle end-of-transaction pulse
  logic       ack_ok;    // with done: 1 = device ACKed, 0 = error
  logic       busy;      // transaction in progress

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, done, ack_ok, busy
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, done, ack_ok, busy
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchroniser for the raw PS/2 clock and data lines plus a
// falling-edge strobe for each. Both lines idle high, so reset loads ones
// to avoid a false edge straight out of reset.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clk_raw_i,
  input  logic dat_raw_i,
  output logic clk_s_o,
  output logic dat_s_o,
  output logic clk_fall_o,
  output logic dat_fall_o
);

  // [0] first flop, [1] synchronised value, [2] synchronised value last cycle
  logic [2:0] clk_sh_q, clk_sh_d;
  logic [2:0] dat_sh_q, dat_sh_d;

  assign clk_sh_d = {clk_sh_q[1:0], clk_raw_i};
  assign dat_sh_d = {dat_sh_q[1:0], dat_raw_i};

  // Shift the raw lines through the synchroniser and history flops.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      clk_sh_q <= '1;
      dat_sh_q <= '1;
    end else begin
      clk_sh_q <= clk_sh_d;
      dat_sh_q <= dat_sh_d;
    end
  end

  assign clk_s_o    = clk_sh_q[1];
  assign dat_s_o    = dat_sh_q[1];
  assign clk_fall_o = clk_sh_q[2] & ~clk_sh_q[1];
  assign dat_fall_o = dat_sh_q[2] & ~dat_sh_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter. Inhibits the bus, issues request-to-send,
// shifts data/parity/stop out on the device's clock falls, then checks the
// device ACK. Lines are open drain: outputs are pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYC  = INHIBIT_CYC_DEF,
  parameter int unsigned RTS_CYC      = RTS_CYC_DEF,
  parameter int unsigned START_TO_CYC = START_TO_CYC_DEF,
  parameter int unsigned PKT_TO_CYC   = PKT_TO_CYC_DEF
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ps2_host_tx_if.slave   host,
  input  logic           ps2_clk_i,
  input  logic           ps2_data_i,
  output logic           ps2_clk_low_o,
  output logic           ps2_data_low_o
);

  // Last counter value of each phase; leaving on it gives exactly N cycles.
  localparam logic [TO_W-1:0] INH_LAST   = TO_W'(INHIBIT_CYC - 1);
  localparam logic [TO_W-1:0] RTS_LAST   = TO_W'(RTS_CYC - 1);
  localparam logic [TO_W-1:0] START_LAST = TO_W'(START_TO_CYC - 1);
  localparam logic [TO_W-1:0] PKT_LAST   = TO_W'(PKT_TO_CYC - 1);
  localparam logic [3:0]      ACK_FALL   = 4'(FRAME_FALLS - 1);

  ps2_tx_state_e   state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [9:0]      sh_q, sh_d;     // {stop, parity, data[7:0]}, LSB goes next
  logic [3:0]      nfall_q, nfall_d;
  logic            drv_q, drv_d;   // data pull-low for the current frame bit
  logic            done_q, done_d;
  logic            ack_q, ack_d;
  logic            live_q;         // low only in the cycle after reset

  logic clk_s, dat_s, clk_fall;
  logic unused_dat_fall;
  logic ready;

  ps2_line_sync u_sync (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clk_raw_i  (ps2_clk_i),
    .dat_raw_i  (ps2_data_i),
    .clk_s_o    (clk_s),
    .dat_s_o    (dat_s),
    .clk_fall_o (clk_fall),
    .dat_fall_o (unused_dat_fall)
  );

  // Saturating so a stuck timeout compare can never wrap back to zero.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  // The done cycle is already IDLE, so ready is held off for it to give the
  // requester one clean cycle to see the status before it can issue again.
  assign ready = (state_q == S_IDLE) && live_q && !done_q;

  // Next-state, frame shifting and status strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    sh_d    = sh_q;
    nfall_d = nfall_q;
    drv_d   = drv_q;
    done_d  = 1'b0;
    ack_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (host.tx_valid && ready) begin
          state_d = S_INHIBIT;
          sh_d    = {1'b1, odd_parity(host.tx_data), host.tx_data};
          nfall_d = '0;
          drv_d   = 1'b0;
        end
      end
      S_INHIBIT: begin
        if (cnt_q >= INH_LAST) state_d = S_RTS;
      end
      S_RTS: begin
        if (cnt_q >= RTS_LAST) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        // Timeout takes priority over a coincident fall.
        if (cnt_q >= START_LAST) begin
          state_d = S_ERR;
        end else if (clk_fall) begin
          state_d = S_SHIFT;
          drv_d   = ~sh_q[0];
          sh_d    = {1'b0, sh_q[9:1]};
          nfall_d = 4'd1;
        end
      end
      S_SHIFT: begin
        // Counter is not cleared per bit: it times the whole packet.
        if (cnt_q >= PKT_LAST) begin
          state_d = S_ERR;
        end else if (clk_fall) begin
          if (nfall_q == ACK_FALL) begin
            state_d = dat_s ? S_ERR : S_DONE_OK;
          end else begin
            drv_d   = ~sh_q[0];
            sh_d    = {1'b0, sh_q[9:1]};
            nfall_d = nfall_q + 4'd1;
          end
        end
      end
      S_DONE_OK, S_ERR: begin
        // Hold until the device has let go of both lines.
        if (clk_s && dat_s) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          ack_d   = (state_q == S_DONE_OK);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      nfall_q <= '0;
      drv_q   <= 1'b0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      nfall_q <= nfall_d;
      drv_q   <= drv_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      live_q  <= 1'b1;
    end
  end

  // Data is held low from RTS through WAIT_START: that is the start bit.
  assign ps2_clk_low_o  = (state_q == S_INHIBIT) || (state_q == S_RTS);
  assign ps2_data_low_o = (state_q == S_RTS) || (state_q == S_WAIT_START) ||
                          ((state_q == S_SHIFT) && drv_q);

  assign host.tx_ready = ready;
  assign host.busy     = (state_q != S_IDLE);
  assign host.done     = done_q;
  assign host.ack_ok   = ack_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model on open-drain lines, a table of
// directed frames, random frames against a parity/ack model, and timeout,
// reset and busy corner cases. Cycle counts are scaled down.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 40;
  localparam int RTSC = 8;
  localparam int STO  = 300;
  localparam int PTO  = 600;
  localparam int HALF = 10;
  localparam int M_ACK  = 0;
  localparam int M_NACK = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ps2_host_tx_if hif ();

  logic dev_clk = 1'b1, dev_dat = 1'b1;
  logic clk_low, dat_low;
  logic clk_line, dat_line;
  assign clk_line = dev_clk & ~clk_low;
  assign dat_line = dev_dat & ~dat_low;

  ps2_host_tx #(
    .INHIBIT_CYC (INH),
    .RTS_CYC     (RTSC),
    .START_TO_CYC(STO),
    .PKT_TO_CYC  (PTO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .host          (hif),
    .ps2_clk_i     (clk_line),
    .ps2_data_i    (dat_line),
    .ps2_clk_low_o (clk_low),
    .ps2_data_low_o(dat_low)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] data;
    int         mode;
    logic [9:0] exp_frame;  // {stop, parity, data} as the device samples them
    logic       exp_ack;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: frame = data LSB first, then a parity bit making the number of
  // ones odd, then a stop bit of 1.
  function automatic logic [9:0] model_frame(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += (b >> i) & 1;
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b};
  endfunction

  task automatic start_tx(input logic [7:0] b);
    int n = 0;
    while (!hif.tx_ready && n < 100) begin tick(); n++; end
    chk("ready_before_send", hif.tx_ready, 1);
    hif.tx_data  = b;
    hif.tx_valid = 1'b1;
    tick();
    hif.tx_valid = 1'b0;
    chk("accept_clk_low", clk_low, 1);
    chk("accept_busy", hif.busy, 1);
  endtask

  // Measures inhibit and RTS lengths; returns on the first released-clock cycle.
  task automatic preamble();
    int inh = 0, rts = 0;
    while (clk_low && !dat_low && inh < INH + 50) begin inh++; tick(); end
    while (clk_low && dat_low && rts < RTSC + 50) begin rts++; tick(); end
    chk("inhibit_cycles", inh, INH);
    chk("rts_cycles", rts, RTSC);
    chk("start_bit_low", dat_line, 0);
  endtask

  // Device clocks nclk falls; samples data on each rise; ACKs per mode.
  task automatic dev_frame(input int nclk, input int mode, output logic [9:0] bits);
    bits = '0;
    repeat (12) tick();
    for (int i = 1; i <= nclk; i++) begin
      if (i == 11) begin
        dev_dat = (mode == M_ACK) ? 1'b0 : 1'b1;
        repeat (3) tick();
      end
      dev_clk = 1'b0;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      if (i <= 10) bits[i-1] = dat_line;
      if (i == 11) dev_dat = 1'b1;
      else repeat (HALF) tick();
    end
  endtask

  task automatic wait_done(input int limit, input logic exp_ack, input string tag);
    int n = 0;
    while (!hif.done && n < limit) begin tick(); n++; end
    chk({tag, "_done_seen"}, hif.done, 1);
    chk({tag, "_ack_ok"}, hif.ack_ok, exp_ack);
    chk({tag, "_lines_released"}, {clk_low, dat_low}, 0);
    chk({tag, "_not_ready_on_done"}, hif.tx_ready, 0);
    tick();
    chk({tag, "_done_one_cycle"}, hif.done, 0);
    chk({tag, "_ready_after_done"}, hif.tx_ready, 1);
    chk({tag, "_idle"}, hif.busy, 0);
  endtask

  task automatic full_tx(input logic [7:0] d, input int mode, input logic [9:0] exp_frame,
                         input logic exp_ack, input string tag);
    logic [9:0] bits;
    start_tx(d);
    preamble();
    dev_frame(11, mode, bits);
    chk({tag, "_frame"}, bits, exp_frame);
    wait_done(100, exp_ack, tag);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    logic [9:0] bits;
    int n;

    vt[0] = '{CMD_ENABLE,   M_ACK,  10'h2F4, 1'b1};
    vt[1] = '{CMD_RESET,    M_ACK,  10'h3FF, 1'b1};
    vt[2] = '{CMD_SET_RATE, M_NACK, 10'h3F3, 1'b0};
    vt[3] = '{8'h00,        M_ACK,  10'h300, 1'b1};
    vt[4] = '{8'h5A,        M_NACK, 10'h35A, 1'b0};

    hif.tx_data  = 8'h00;
    hif.tx_valid = 1'b0;

    // Reset state
    tick(); tick();
    chk("rst_lines", {clk_low, dat_low}, 0);
    chk("rst_status", {hif.done, hif.ack_ok, hif.busy, hif.tx_ready}, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_release_ready", hif.tx_ready, 1);

    // Spurious line activity in IDLE
    for (int i = 0; i < 4; i++) begin
      dev_clk = i[0];
      dev_dat = ~i[1];
      repeat (4) tick();
      chk("idle_spurious_busy", {hif.busy, clk_low, dat_low, hif.done}, 0);
    end
    dev_clk = 1'b1; dev_dat = 1'b1;
    repeat (4) tick();

    // Directed table
    for (int i = 0; i < 5; i++)
      full_tx(vt[i].data, vt[i].mode, vt[i].exp_frame, vt[i].exp_ack, "vec");

    // Random frames against the model
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      int m;
      d = 8'($urandom_range(0, 255));
      m = int'($urandom_range(0, 1));
      full_tx(d, m, model_frame(d), (m == M_ACK), "rand");
    end

    // Device never clocks: error exactly STO cycles after clock release
    start_tx(CMD_ENABLE);
    preamble();
    n = 0;
    while (dat_low && n < STO + 50) begin n++; tick(); end
    chk("noclk_timeout_cycles", n, STO);
    wait_done(50, 1'b0, "noclk");

    // Device stalls after 5 bits: error PTO cycles after the first fall is acted on
    start_tx(8'h00);
    preamble();
    repeat (12) tick();
    n = 0;
    for (int i = 1; i <= 5; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) begin tick(); n++; end
      dev_clk = 1'b1;
      repeat (HALF) begin tick(); n++; end
    end
    chk("stall_still_driving", dat_low, 1);
    while (dat_low && n < 3 + PTO + 50) begin tick(); n++; end
    chk("stall_pkt_timeout_cycles", n, 3 + PTO);
    wait_done(50, 1'b0, "stall");

    // Reset during bit 4
    start_tx(8'h00);
    preamble();
    repeat (12) tick();
    for (int i = 1; i <= 3; i++) begin
      dev_clk = 1'b0; repeat (HALF) tick();
      dev_clk = 1'b1; repeat (HALF) tick();
    end
    dev_clk = 1'b0;
    repeat (5) tick();
    chk("bit4_driving", dat_low, 1);
    rst_n = 1'b0;
    tick();
    chk("midrst_lines", {clk_low, dat_low}, 0);
    chk("midrst_status", {hif.busy, hif.tx_ready, hif.done}, 0);
    rst_n = 1'b1;
    dev_clk = 1'b1;
    tick();
    chk("midrst_ready_after_release", hif.tx_ready, 1);
    repeat (20) tick();
    chk("midrst_stays_idle", {hif.busy, clk_low, dat_low}, 0);

    // tx_valid while busy is dropped, not queued
    start_tx(CMD_ENABLE);
    hif.tx_data  = 8'h11;
    hif.tx_valid = 1'b1;
    preamble();
    dev_frame(11, M_ACK, bits);
    hif.tx_valid = 1'b0;
    chk("busyreq_frame", bits, model_frame(CMD_ENABLE));
    wait_done(100, 1'b1, "busyreq");
    n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (hif.busy || clk_low) n++;
    end
    chk("busyreq_no_second_tx", n, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
